// File: rtl/adsr_pkg.sv
// ADSR envelope shared definitions: stage codes,
// Q1.15 gain limits and default envelope shape.
package adsr_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } stage_t;

   localparam logic [15:0] GAIN_MAX  = 16'h7FFF;
   localparam logic [15:0] GAIN_ZERO = 16'h0000;

   localparam logic [15:0] DEF_ATTACK_STEP   = 16'd64;
   localparam logic [15:0] DEF_DECAY_STEP    = 16'd16;
   localparam logic [15:0] DEF_SUSTAIN_LEVEL = 16'h4000;
   localparam logic [15:0] DEF_RELEASE_STEP  = 16'd8;

endpackage

// File: rtl/adsr_sequencer_if.sv
// Note events, sample strobe and enveloped output
// bundle between the sequencer and its driver.
interface adsr_sequencer_if;
   logic        note_on;
   logic        note_off;
   logic        in_ready;
   logic [15:0] pre_sample_in;
   logic [15:0] sample_out;
   logic        out_valid;
   logic [15:0] gain;
   logic [2:0]  stage;
   logic        busy;

   modport master (
      output note_on, note_off, in_ready, pre_sample_in,
      input  sample_out, out_valid, gain, stage, busy
   );

   modport slave (
      input  note_on, note_off, in_ready, pre_sample_in,
      output sample_out, out_valid, gain, stage, busy
   );
endinterface

// File: rtl/adsr_gain_mult.sv
// Registered signed sample times unsigned Q1.15 gain,
// with a one-cycle valid pulse per sample strobe.
module adsr_gain_mult (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_ready,
   input  logic signed [15:0] pre_sample_in,
   input  logic        [15:0] gain,
   output logic signed [15:0] sample_out,
   output logic               out_valid
);

   logic signed [31:0] prod;

   assign prod = pre_sample_in * $signed({1'b0, gain});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_out <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= in_ready;
         if (in_ready)
            sample_out <= 16'(prod >>> 15);
      end
   end

endmodule

// File: rtl/adsr_sequencer.sv
// ADSR envelope FSM and gain register; the gain scales
// each strobed oscillator sample through adsr_gain_mult.
module adsr_sequencer
   import adsr_pkg::*;
#(
   parameter logic [15:0] ATTACK_STEP   = DEF_ATTACK_STEP,
   parameter logic [15:0] DECAY_STEP    = DEF_DECAY_STEP,
   parameter logic [15:0] SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
   parameter logic [15:0] RELEASE_STEP  = DEF_RELEASE_STEP
) (
   input logic               clk,
   input logic               reset,
   adsr_sequencer_if.slave   bus
);

   stage_t             state_q, state_d;
   logic        [15:0] gain_q, gain_d;
   logic        [16:0] att_sum;
   logic signed [16:0] dec_diff;

   assign att_sum  = {1'b0, gain_q} + {1'b0, ATTACK_STEP};
   assign dec_diff = $signed({1'b0, gain_q})
                   - $signed({1'b0, DECAY_STEP});

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         gain_q  <= GAIN_ZERO;
      end else begin
         state_q <= state_d;
         gain_q  <= gain_d;
      end
   end

   // Note events only change state; steps need a quiet strobe.
   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      if (bus.note_on) begin
         state_d = S_ATTACK;
      end else if (bus.note_off) begin
         if (state_q inside {S_ATTACK, S_DECAY, S_SUSTAIN})
            state_d = S_RELEASE;
      end else if (bus.in_ready) begin
         case (state_q)
            S_IDLE: gain_d = GAIN_ZERO;
            S_ATTACK: begin
               if (att_sum >= {1'b0, GAIN_MAX}) begin
                  gain_d  = GAIN_MAX;
                  state_d = S_DECAY;
               end else begin
                  gain_d = att_sum[15:0];
               end
            end
            S_DECAY: begin
               if (dec_diff <= $signed({1'b0, SUSTAIN_LEVEL})) begin
                  gain_d  = SUSTAIN_LEVEL;
                  state_d = S_SUSTAIN;
               end else begin
                  gain_d = dec_diff[15:0];
               end
            end
            S_SUSTAIN: gain_d = SUSTAIN_LEVEL;
            S_RELEASE: begin
               if (gain_q <= RELEASE_STEP) begin
                  gain_d  = GAIN_ZERO;
                  state_d = S_IDLE;
               end else begin
                  gain_d = gain_q - RELEASE_STEP;
               end
            end
            default: begin
               gain_d  = GAIN_ZERO;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   assign bus.gain  = gain_q;
   assign bus.stage = state_q;
   assign bus.busy  = (state_q != S_IDLE);

   adsr_gain_mult u_mult (
      .clk           (clk),
      .reset         (reset),
      .in_ready      (bus.in_ready),
      .pre_sample_in (bus.pre_sample_in),
      .gain          (gain_q),
      .sample_out    (bus.sample_out),
      .out_valid     (bus.out_valid)
   );

endmodule

// File: tb/tb_adsr_sequencer.sv
// Directed bench for adsr_sequencer: envelope walk plus
// queued expected samples checked on each out_valid.
module tb_adsr_sequencer;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   adsr_sequencer_if ifc ();

   adsr_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   int vectors     = 0;
   int miscompares = 0;
   int sb[$];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic int scale(input int pre, input int g);
      longint p;
      p = longint'(pre) * longint'(g);
      return int'(p >>> 15);
   endfunction

   // Output checker: every out_valid consumes one expected sample.
   always @(negedge clk) begin
      if (reset && ifc.out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            int e;
            e = sb.pop_front();
            chk("sample_out", int'($signed(ifc.sample_out)), e);
         end
      end
   end

   // One cycle of inputs; an expected sample is queued on strobes.
   task automatic cyc(input logic on, input logic off, input logic rdy,
                      input int pre, input int g_before);
      ifc.note_on       = on;
      ifc.note_off      = off;
      ifc.in_ready      = rdy;
      ifc.pre_sample_in = 16'(pre);
      if (rdy)
         sb.push_back(scale(pre, g_before));
      @(posedge clk);
      #1;
      ifc.note_on  = 1'b0;
      ifc.note_off = 1'b0;
      ifc.in_ready = 1'b0;
   endtask

   task automatic strobe(input int pre, input int g_before);
      cyc(1'b0, 1'b0, 1'b1, pre, g_before);
   endtask

   initial begin
      reset             = 1'b0;
      ifc.note_on       = 1'b0;
      ifc.note_off      = 1'b0;
      ifc.in_ready      = 1'b0;
      ifc.pre_sample_in = '0;
      #12;
      chk("rst_gain",   int'(ifc.gain), 0);
      chk("rst_stage",  int'(ifc.stage), 0);
      chk("rst_busy",   int'(ifc.busy), 0);
      chk("rst_sample", int'(ifc.sample_out), 0);
      chk("rst_valid",  int'(ifc.out_valid), 0);

      @(posedge clk);
      #1 reset = 1'b1;

      // Attack from zero
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("on_stage", int'(ifc.stage), 1);
      chk("on_gain",  int'(ifc.gain), 0);
      for (int k = 1; k <= 511; k++)
         strobe(32767, 64 * (k - 1));
      chk("att511_gain",  int'(ifc.gain), 32704);
      chk("att511_stage", int'(ifc.stage), 1);
      strobe(32767, 32704);
      chk("att512_gain",  int'(ifc.gain), 32767);
      chk("att512_stage", int'(ifc.stage), 2);

      // Decay into sustain
      for (int k = 1; k <= 1023; k++)
         strobe(32767, 32767 - 16 * (k - 1));
      chk("dec1023_gain",  int'(ifc.gain), 16399);
      chk("dec1023_stage", int'(ifc.stage), 2);
      strobe(32767, 16399);
      chk("dec1024_gain",  int'(ifc.gain), 16384);
      chk("dec1024_stage", int'(ifc.stage), 3);
      for (int k = 0; k < 100; k++)
         strobe(32767, 16384);
      chk("sus_gain",  int'(ifc.gain), 16384);
      chk("sus_stage", int'(ifc.stage), 3);

      // Release; note_off with a strobe must not step the gain
      cyc(1'b0, 1'b1, 1'b1, 32767, 16384);
      chk("off_stage", int'(ifc.stage), 4);
      chk("off_gain",  int'(ifc.gain), 16384);
      for (int k = 1; k <= 2047; k++)
         strobe(-32768, 16384 - 8 * (k - 1));
      chk("rel2047_gain",  int'(ifc.gain), 8);
      chk("rel2047_stage", int'(ifc.stage), 4);
      strobe(-32768, 8);
      chk("rel2048_gain",  int'(ifc.gain), 0);
      chk("rel2048_stage", int'(ifc.stage), 0);
      chk("rel2048_busy",  int'(ifc.busy), 0);
      cyc(1'b0, 1'b1, 1'b0, 0, 0);
      chk("idle_off_stage", int'(ifc.stage), 0);

      // Back to full gain for the datapath corners
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 512; k++)
         strobe(0, 0);
      chk("att2_gain",  int'(ifc.gain), 32767);
      chk("att2_stage", int'(ifc.stage), 2);
      strobe(32767, 32767);
      chk("dp_valid", int'(ifc.out_valid), 1);
      chk("dp_max", int'($signed(ifc.sample_out)), 32766);
      cyc(1'b1, 1'b0, 1'b0, 0, 0);
      chk("retrig_stage", int'(ifc.stage), 1);
      chk("retrig_gain",  int'(ifc.gain), 32751);
      strobe(0, 32751);
      chk("retrig_top_gain",  int'(ifc.gain), 32767);
      chk("retrig_top_stage", int'(ifc.stage), 2);
      strobe(-32768, 32767);
      chk("dp_min", int'($signed(ifc.sample_out)), -32767);
      @(posedge clk);
      #1;
      chk("dp_valid_drop", int'(ifc.out_valid), 0);
      chk("dp_hold", int'($signed(ifc.sample_out)), -32767);

      // Collision during release
      cyc(1'b0, 1'b1, 1'b0, 0, 0);
      chk("rel2_stage", int'(ifc.stage), 4);
      for (int k = 0; k < 3; k++)
         strobe(0, 0);
      chk("rel2_gain", int'(ifc.gain), 32727);
      cyc(1'b1, 1'b1, 1'b1, 0, 0);
      chk("coll_stage", int'(ifc.stage), 1);
      chk("coll_gain",  int'(ifc.gain), 32727);

      // Reset in the middle of decay
      strobe(0, 32727);
      for (int k = 1; k <= 512; k++)
         strobe(16384, 32767 - 16 * (k - 1));
      chk("mid_gain", int'(ifc.gain), 24575);
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("arst_gain",   int'(ifc.gain), 0);
      chk("arst_stage",  int'(ifc.stage), 0);
      chk("arst_sample", int'(ifc.sample_out), 0);
      chk("arst_busy",   int'(ifc.busy), 0);

      // First edge after release acts normally
      #1;
      reset       = 1'b1;
      ifc.note_on = 1'b1;
      @(posedge clk);
      #1 ifc.note_on = 1'b0;
      chk("post_rst_stage", int'(ifc.stage), 1);
      chk("post_rst_gain",  int'(ifc.gain), 0);

      @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adsr_sequencer.md
ADSR_SEQUENCER -- requirements
Module: adsr_sequencer

Interface
REQ-001 Parameter ATTACK_STEP, default 16'd64, gain increment per sample strobe in ATTACK.
REQ-002 Parameter DECAY_STEP, default 16'd16, gain decrement per sample strobe in DECAY.
REQ-003 Parameter SUSTAIN_LEVEL, default 16'h4000, sustain gain in Q1.15, legal range 1..16'h7FFE.
REQ-004 Parameter RELEASE_STEP, default 16'd8, gain decrement per sample strobe in RELEASE.
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 note_on  input  1  single-cycle key-press pulse.
REQ-009 note_off  input  1  single-cycle key-release pulse.
REQ-010 in_ready  input  1  sample strobe: pre_sample_in is valid and the envelope advances one step.
REQ-011 pre_sample_in  input  16  signed raw oscillator sample.
REQ-012 sample_out  output  16  signed enveloped sample.
REQ-013 out_valid  output  1  sample_out is updated this cycle.
REQ-014 gain  output  16  current envelope gain, unsigned Q1.15, range 0..16'h7FFF.
REQ-015 stage  output  3  current state code.
REQ-016 busy  output  1  high when stage is not IDLE.

Function
REQ-017 States and codes: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; codes 5-7 are unreachable and decode to IDLE.
REQ-018 note_on in any state moves to ATTACK on the next edge; gain is retained (retrigger does not restart from zero).
REQ-019 note_off in ATTACK, DECAY or SUSTAIN moves to RELEASE on the next edge; in IDLE or RELEASE it is ignored.
REQ-020 With note_on and note_off both high in one cycle, note_on takes priority.
REQ-021 A cycle carrying note_on or note_off performs the state change only; no gain step is applied in that cycle, even if in_ready is high.
REQ-022 Gain steps occur only on cycles with in_ready high and no note event; gain holds on all other cycles.
REQ-023 ATTACK step: if gain + ATTACK_STEP >= 16'h7FFF, gain becomes 16'h7FFF and state becomes DECAY on the same edge; otherwise gain += ATTACK_STEP.
REQ-024 DECAY step: if gain - DECAY_STEP <= SUSTAIN_LEVEL, gain becomes SUSTAIN_LEVEL and state becomes SUSTAIN; otherwise gain -= DECAY_STEP. Compare with 17-bit signed arithmetic so no underflow occurs.
REQ-025 SUSTAIN: gain is held at SUSTAIN_LEVEL until note_off or note_on.
REQ-026 RELEASE step: if gain <= RELEASE_STEP, gain becomes 0 and state becomes IDLE; otherwise gain -= RELEASE_STEP.
REQ-027 IDLE: gain is 0.
REQ-028 Datapath: on an in_ready cycle, sample_out is registered as (pre_sample_in * {1'b0,gain}) >>> 15, using a 32-bit signed product and arithmetic (floor) shift.
REQ-029 The datapath uses the gain value present before that edge's update.
REQ-030 out_valid pulses one cycle per in_ready with 1-cycle latency; sample_out holds between strobes.
REQ-031 in_ready asserted on consecutive cycles is legal; each cycle produces one output and one gain step.

Reset
REQ-032 While reset=0: stage=IDLE, gain=0, sample_out=0, out_valid=0, busy=0, asynchronously.
REQ-033 Reset asserted mid-envelope aborts to IDLE with no release tail.
REQ-034 The first edge after deassertion processes inputs normally.

Structure
REQ-035 Package adsr_pkg holds the stage encoding, the Q1.15 constants GAIN_MAX=16'h7FFF and GAIN_ZERO, and the default step and sustain values.
REQ-036 One sub-module, adsr_gain_mult, holds the registered signed-by-unsigned Q1.15 multiply and out_valid generation; the FSM and gain register live in adsr_sequencer.

Verification
REQ-037 Attack: reset, note_on, then 512 in_ready strobes -> gain reaches 16'h7FFF and stage=2 exactly at strobe 512; after 511 strobes gain=32704.
REQ-038 Decay/sustain: continue 1024 strobes -> gain=16'h4000 and stage=3 at strobe 1024; 100 further strobes leave gain=16'h4000.
REQ-039 Release: note_off in SUSTAIN -> stage=4 next cycle; 2048 strobes -> gain=0, stage=0, busy=0.
REQ-040 Datapath: gain=16'h7FFF with pre_sample_in=16'h7FFF -> sample_out=16'h7FFE; pre_sample_in=16'h8000 -> sample_out=-32767; out_valid one cycle after in_ready.
REQ-041 Collision: note_on and note_off together during RELEASE with in_ready high -> stage=1, gain unchanged that cycle.
REQ-042 Reset mid-DECAY (gain about 16'h6000) -> gain=0, stage=0, sample_out=0 immediately, without waiting for a clock edge.
